// File: rtl/alu_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer and its combinational core.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned OP_W         = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    // Codes from here up to 4'hF carry no operation.
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_SEND
    } seq_state_e;

    localparam int unsigned FLAG_ZERO_BIT    = 0;
    localparam int unsigned FLAG_ILLEGAL_BIT = 1;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I integer ALU: result, illegal-op and zero indications.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal,
    output logic            o_zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;

    // Shifts honour only the low log2(XLEN) bits of B.
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_op))
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SLT:  o_result = XLEN'($signed(i_a) < $signed(i_b));
            OP_SLTU: o_result = XLEN'(i_a < i_b);
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = XLEN'($signed(i_a) >>> w_shamt);
            OP_OR:   o_result = i_a | i_b;
            OP_AND:  o_result = i_a & i_b;
            default: o_result = '0;
        endcase
    end

    assign o_illegal = (i_op >= OP_ILLEGAL_MIN);
    assign o_zero    = (o_result == '0);

endmodule

// File: rtl/alu_byte_sequencer.sv
// Byte-serial front end: collects opcode/A/B over a valid/ready stream, runs the ALU
// for one cycle, and returns result bytes plus a flags byte over a second stream.
module alu_byte_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    input  logic       abort,
    output logic       busy,
    output logic       done
);

    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned CW     = $clog2(NBYTES + 1);
    localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    seq_state_e             r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [OP_W-1:0]        r_op, w_op_nxt;
    logic [NBYTES-1:0][7:0] r_a, w_a_nxt;
    logic [NBYTES-1:0][7:0] r_b, w_b_nxt;
    logic [NBYTES-1:0][7:0] r_result, w_result_nxt;
    logic [7:0]             r_flags, w_flags_nxt;
    logic                   r_in_ready, w_in_ready_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic [7:0]             r_out_data, w_out_data_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;

    logic [XLEN-1:0]        w_alu_result;
    logic                   w_alu_illegal;
    logic                   w_alu_zero;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last_byte;
    logic                   w_cnt_is_flags;
    logic [IW-1:0]          w_idx;
    logic [IW-1:0]          w_idx_nxt;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_illegal(w_alu_illegal),
        .o_zero   (w_alu_zero)
    );

    assign w_in_fire      = in_valid && r_in_ready;
    assign w_out_fire     = r_out_valid && out_ready;
    assign w_last_byte    = (r_cnt == CW'(NBYTES - 1));
    assign w_cnt_is_flags = (r_cnt == CW'(NBYTES));
    assign w_idx          = r_cnt[IW-1:0];
    assign w_idx_nxt      = w_cnt_nxt[IW-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_result_nxt = r_result;
        w_flags_nxt  = r_flags;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_op_nxt    = in_data[OP_W-1:0];
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (w_in_fire) begin
                    w_a_nxt[w_idx] = in_data;
                    if (w_last_byte) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_LOAD_B;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (w_in_fire) begin
                    w_b_nxt[w_idx] = in_data;
                    if (w_last_byte) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            ST_EXEC: begin
                w_result_nxt                   = w_alu_result;
                w_flags_nxt                    = '0;
                w_flags_nxt[FLAG_ZERO_BIT]     = w_alu_zero;
                w_flags_nxt[FLAG_ILLEGAL_BIT]  = w_alu_illegal;
                w_cnt_nxt                      = '0;
                w_state_nxt                    = ST_SEND;
            end
            ST_SEND: begin
                if (w_out_fire) begin
                    if (w_cnt_is_flags) begin
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides any handshake; in IDLE there is nothing to discard.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_done_nxt   = 1'b0;
            w_result_nxt = '0;
            w_flags_nxt  = '0;
        end

        // Outputs are registered from the next state so they align with it.
        w_in_ready_nxt  = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD_A) ||
                          (w_state_nxt == ST_LOAD_B);
        w_out_valid_nxt = (w_state_nxt == ST_SEND);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_out_data_nxt  = 8'h00;
        if (w_state_nxt == ST_SEND) begin
            w_out_data_nxt = (w_cnt_nxt == CW'(NBYTES)) ? w_flags_nxt : w_result_nxt[w_idx_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_result    <= w_result_nxt;
            r_flags     <= w_flags_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Scoreboard bench for alu_byte_sequencer: directed frames queue their expected bytes,
// a monitor pops and compares on every output transfer.
module tb_alu_byte_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       abort;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] data;
        bit         last;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks       = 0;
    int   errors       = 0;
    bit   mon_en       = 1'b1;
    bit   pending_done = 1'b0;
    int   stall_byte   = -1;
    int   stall_cycles = 0;

    alu_byte_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .abort    (abort),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input bit last, input string name);
        exp_t e;
        e.data = d;
        e.last = last;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Holds in_valid/in_data until the byte is taken on a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready stuck at 0 for byte %02h", b);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] res, input logic [7:0] flags);
        int n;
        for (int i = 0; i < 4; i++) push_exp(res[8*i +: 8], 1'b0, $sformatf("%s_res%0d", tag, i));
        push_exp(flags, 1'b1, $sformatf("%s_flags", tag));
        send_frame(op, a, b);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d bytes outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        int   byte_idx;
        byte_idx = 0;
        forever begin
            @(negedge clk);
            if (pending_done) begin
                check1("done_pulse", done, 1'b1);
                pending_done = 1'b0;
            end else if (done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got 1 required 0");
            end
            if (mon_en && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %02h with empty scoreboard", out_data);
                    out_ready = 1'b1;
                end else if (byte_idx == stall_byte && stall_cycles > 0) begin
                    out_ready = 1'b0;
                    check8("stall_hold", out_data, exp_q[0].data);
                    stall_cycles--;
                end else begin
                    out_ready = 1'b1;
                    e = exp_q.pop_front();
                    check8(e.name, out_data, e.data);
                    if (e.last) begin
                        byte_idx     = 0;
                        pending_done = 1'b1;
                    end else begin
                        byte_idx++;
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        abort     = 1'b0;
        fork
            monitor();
        join_none

        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check8("rst_out_data", out_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_frame("add",    8'h00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 8'h00);
        run_frame("sub",    8'h01, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 8'h01);
        run_frame("sub_f1", 8'hF1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 8'h01);
        run_frame("sra",    8'h07, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 8'h00);
        run_frame("slt",    8'h03, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 8'h00);
        run_frame("sltu",   8'h04, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 8'h01);
        run_frame("sll",    8'h02, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 8'h00);
        run_frame("srl",    8'h06, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 8'h00);
        run_frame("xor",    8'h05, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 8'h00);
        run_frame("and",    8'h09, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 8'h00);
        run_frame("or",     8'h08, 32'h0000_0011, 32'h2200_0000, 32'h2200_0011, 8'h00);
        run_frame("addwrap",8'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 8'h01);

        stall_byte   = 2;
        stall_cycles = 3;
        run_frame("illegal", 8'h0C, 32'h1122_3344, 32'h5566_7788, 32'h0000_0000, 8'h03);
        stall_byte   = -1;

        // Abort after three A bytes, then a clean frame.
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        @(negedge clk);
        in_valid = 1'b0;
        check1("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check1("abort_busy", busy, 1'b0);
        check1("abort_in_ready", in_ready, 1'b1);
        check1("abort_out_valid", out_valid, 1'b0);
        run_frame("post_abort", 8'h00, 32'h0000_0007, 32'h0000_0009, 32'h0000_0010, 8'h00);

        // Asynchronous reset while the result is being presented.
        mon_en = 1'b0;
        send_frame(8'h00, 32'h0000_0001, 32'h0000_0002);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("send_reached", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("async_rst_out_valid", out_valid, 1'b0);
        check1("async_rst_in_ready", in_ready, 1'b1);
        check1("async_rst_busy", busy, 1'b0);
        check8("async_rst_out_data", out_data, 8'h00);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        run_frame("post_rst", 8'h00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
